// File: rtl/mem_mon_pkg.sv
// Shared constants for the LA memory self-test monitor: status codes,
// FSM state encoding and stage encoding.
package mem_mon_pkg;

  localparam int unsigned CODE_W = 16;

  localparam logic [CODE_W-1:0] CODE_WORD_START  = 16'hA040;
  localparam logic [CODE_W-1:0] CODE_WORD_FAIL   = 16'hAB40;
  localparam logic [CODE_W-1:0] CODE_WORD_PASS   = 16'hAB41;
  localparam logic [CODE_W-1:0] CODE_SHORT_START = 16'hA020;
  localparam logic [CODE_W-1:0] CODE_SHORT_FAIL  = 16'hAB20;
  localparam logic [CODE_W-1:0] CODE_SHORT_PASS  = 16'hAB21;
  localparam logic [CODE_W-1:0] CODE_BYTE_START  = 16'hA010;
  localparam logic [CODE_W-1:0] CODE_BYTE_FAIL   = 16'hAB10;
  localparam logic [CODE_W-1:0] CODE_BYTE_PASS   = 16'hAB11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W_RUN  = 3'd1,
    ST_W_DONE = 3'd2,
    ST_S_RUN  = 3'd3,
    ST_S_DONE = 3'd4,
    ST_B_RUN  = 3'd5,
    ST_PASS   = 3'd6,
    ST_FAIL   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    STAGE_IDLE  = 2'd0,
    STAGE_WORD  = 2'd1,
    STAGE_SHORT = 2'd2,
    STAGE_BYTE  = 2'd3
  } stage_e;

  // True for any of the nine protocol codes.
  function automatic logic is_recognised(input logic [CODE_W-1:0] code);
    return (code == CODE_WORD_START)  || (code == CODE_WORD_FAIL)  || (code == CODE_WORD_PASS)  ||
           (code == CODE_SHORT_START) || (code == CODE_SHORT_FAIL) || (code == CODE_SHORT_PASS) ||
           (code == CODE_BYTE_START)  || (code == CODE_BYTE_FAIL)  || (code == CODE_BYTE_PASS);
  endfunction

  // Stage a start code opens; STAGE_IDLE for non-start codes.
  function automatic stage_e start_stage(input logic [CODE_W-1:0] code);
    if (code == CODE_WORD_START)  return STAGE_WORD;
    if (code == CODE_SHORT_START) return STAGE_SHORT;
    if (code == CODE_BYTE_START)  return STAGE_BYTE;
    return STAGE_IDLE;
  endfunction

endpackage

// File: rtl/la_code_sampler.sv
// Debounces the status word: a recognised code is accepted once it has been
// stable for STABLE_CYCLES sampled edges and differs from the last accepted code.
module la_code_sampler
  import mem_mon_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_accept_c,
  output logic [CODE_W-1:0] o_code_c
);

  localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);

  logic [CODE_W-1:0] r_prev;
  logic [CODE_W-1:0] r_last;
  logic [RUN_W-1:0]  r_run;
  logic [RUN_W-1:0]  w_run;

  // Length of the current stable run including this edge, saturating at the threshold.
  always_comb begin
    w_run = RUN_W'(1);
    if (i_code == r_prev) begin
      w_run = (r_run == RUN_W'(STABLE_CYCLES)) ? r_run : r_run + RUN_W'(1);
    end
  end

  assign o_accept_c = !i_clear && (w_run == RUN_W'(STABLE_CYCLES)) &&
                      is_recognised(i_code) && (i_code != r_last);
  assign o_code_c   = i_code;

  // Previous sample, run length and last-accepted code; clear restarts all three.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
      r_run  <= '0;
      r_last <= '0;
    end else if (i_clear) begin
      r_prev <= '0;
      r_run  <= '0;
      r_last <= '0;
    end else begin
      r_prev <= i_code;
      r_run  <= w_run;
      if (o_accept_c) r_last <= i_code;
    end
  end

endmodule

// File: rtl/la_mem_test_monitor.sv
// Memory self-test checkpoint monitor: tracks word/short/byte phases from the
// firmware status word and keeps sticky pass/fail status.
// Optional timeout supervision is built when MEM_MON_TIMEOUT_EN is defined.
module la_mem_test_monitor
  import mem_mon_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 300000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic              core_clk,
  input  logic              core_rstn,
  input  logic [CODE_W-1:0] checkbits,
  input  logic              clear,
  output logic              event_valid,
  output logic [CODE_W-1:0] event_code,
  output logic [1:0]        stage,
  output logic [2:0]        pass_mask,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              seq_err,
  output logic              timeout,
  output logic [CODE_W-1:0] fail_code
);

  // Left empty on purpose: its presence in the hierarchy flags an illegal parameter set.
  if ((STABLE_CYCLES < 1) || (CNT_W < 64 && 64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W))) begin : g_cfg_range_violation
  end

  logic              w_accept;
  logic [CODE_W-1:0] w_code;
  logic              w_terminal;
  logic              w_timeout_hit;

  state_e            r_state,      w_state_nxt;
  logic              r_event_valid, w_ev_valid_nxt;
  logic [CODE_W-1:0] r_event_code, w_ev_code_nxt;
  stage_e            r_stage,      w_stage_nxt;
  logic [2:0]        r_pass_mask,  w_pass_mask_nxt;
  logic              r_done,       w_done_nxt;
  logic              r_pass,       w_pass_nxt;
  logic              r_fail,       w_fail_nxt;
  logic              r_seq_err,    w_seq_err_nxt;
  logic              r_timeout,    w_timeout_nxt;
  logic [CODE_W-1:0] r_fail_code,  w_fail_code_nxt;
  logic              w_phase_fail;
  logic              w_is_seq;

  la_code_sampler #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sampler (
    .i_clk      (core_clk),
    .i_rst_n    (core_rstn),
    .i_clear    (clear),
    .i_code     (checkbits),
    .o_accept_c (w_accept),
    .o_code_c   (w_code)
  );

  assign w_terminal = (r_state == ST_PASS) || (r_state == ST_FAIL);

`ifdef MEM_MON_TIMEOUT_EN
  logic [CNT_W-1:0] r_tcnt;

  // Cycles spent in non-terminal states since reset/clear, saturating at the trip point.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_tcnt <= '0;
    end else if (clear) begin
      r_tcnt <= '0;
    end else if (!w_terminal && (r_tcnt != CNT_W'(TIMEOUT_CYCLES - 1))) begin
      r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  assign w_timeout_hit = !w_terminal && (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  // Next state and next status; an accepted event wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_ev_valid_nxt  = 1'b0;
    w_ev_code_nxt   = r_event_code;
    w_stage_nxt     = r_stage;
    w_pass_mask_nxt = r_pass_mask;
    w_pass_nxt      = r_pass;
    w_fail_nxt      = r_fail;
    w_seq_err_nxt   = r_seq_err;
    w_timeout_nxt   = r_timeout;
    w_fail_code_nxt = r_fail_code;
    w_phase_fail    = 1'b0;
    w_is_seq        = 1'b0;

    if (w_accept) begin
      w_ev_valid_nxt = 1'b1;
      w_ev_code_nxt  = w_code;
      if (!w_terminal) begin
        if (start_stage(w_code) != STAGE_IDLE) w_stage_nxt = start_stage(w_code);
        case (r_state)
          ST_IDLE: begin
            if (w_code == CODE_WORD_START) w_state_nxt = ST_W_RUN;
            else                           w_is_seq    = 1'b1;
          end
          ST_W_RUN: begin
            if (w_code == CODE_WORD_PASS) begin
              w_state_nxt        = ST_W_DONE;
              w_pass_mask_nxt[2] = 1'b1;
            end else if (w_code == CODE_WORD_FAIL) begin
              w_phase_fail = 1'b1;
            end else begin
              w_is_seq = 1'b1;
            end
          end
          ST_W_DONE: begin
            if (w_code == CODE_SHORT_START) w_state_nxt = ST_S_RUN;
            else                            w_is_seq    = 1'b1;
          end
          ST_S_RUN: begin
            if (w_code == CODE_SHORT_PASS) begin
              w_state_nxt        = ST_S_DONE;
              w_pass_mask_nxt[1] = 1'b1;
            end else if (w_code == CODE_SHORT_FAIL) begin
              w_phase_fail = 1'b1;
            end else begin
              w_is_seq = 1'b1;
            end
          end
          ST_S_DONE: begin
            if (w_code == CODE_BYTE_START) w_state_nxt = ST_B_RUN;
            else                           w_is_seq    = 1'b1;
          end
          ST_B_RUN: begin
            if (w_code == CODE_BYTE_PASS) begin
              w_state_nxt        = ST_PASS;
              w_pass_mask_nxt[0] = 1'b1;
              w_pass_nxt         = 1'b1;
            end else if (w_code == CODE_BYTE_FAIL) begin
              w_phase_fail = 1'b1;
            end else begin
              w_is_seq = 1'b1;
            end
          end
          default: w_is_seq = 1'b0;
        endcase
        if (w_phase_fail || w_is_seq) begin
          w_state_nxt     = ST_FAIL;
          w_fail_nxt      = 1'b1;
          w_seq_err_nxt   = w_is_seq;
          w_fail_code_nxt = w_code;
        end
      end
    end else if (w_timeout_hit) begin
      w_state_nxt     = ST_FAIL;
      w_fail_nxt      = 1'b1;
      w_timeout_nxt   = 1'b1;
      w_fail_code_nxt = r_event_code;
    end

    w_done_nxt = r_done || (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
  end

  // State and status registers; clear restarts the monitor ahead of any event.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_state       <= ST_IDLE;
      r_event_valid <= 1'b0;
      r_event_code  <= '0;
      r_stage       <= STAGE_IDLE;
      r_pass_mask   <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_seq_err     <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_code   <= '0;
    end else if (clear) begin
      r_state       <= ST_IDLE;
      r_event_valid <= 1'b0;
      r_event_code  <= '0;
      r_stage       <= STAGE_IDLE;
      r_pass_mask   <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_seq_err     <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_code   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_event_valid <= w_ev_valid_nxt;
      r_event_code  <= w_ev_code_nxt;
      r_stage       <= w_stage_nxt;
      r_pass_mask   <= w_pass_mask_nxt;
      r_done        <= w_done_nxt;
      r_pass        <= w_pass_nxt;
      r_fail        <= w_fail_nxt;
      r_seq_err     <= w_seq_err_nxt;
      r_timeout     <= w_timeout_nxt;
      r_fail_code   <= w_fail_code_nxt;
    end
  end

  assign event_valid = r_event_valid;
  assign event_code  = r_event_code;
  assign stage       = r_stage;
  assign pass_mask   = r_pass_mask;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign seq_err     = r_seq_err;
  assign timeout     = r_timeout;
  assign fail_code   = r_fail_code;

endmodule

// File: tb/tb_la_mem_test_monitor.sv
// Directed bench for la_mem_test_monitor (STABLE_CYCLES=2, TIMEOUT_CYCLES=100).
module tb_la_mem_test_monitor;

  logic        core_clk = 1'b0;
  logic        core_rstn = 1'b0;
  logic [15:0] checkbits = 16'h0000;
  logic        clear = 1'b0;
  logic        event_valid;
  logic [15:0] event_code;
  logic [1:0]  stage;
  logic [2:0]  pass_mask;
  logic        done;
  logic        pass;
  logic        fail;
  logic        seq_err;
  logic        timeout;
  logic [15:0] fail_code;

  int checks = 0;
  int failures = 0;
  int ev_cnt = 0;

  la_mem_test_monitor #(
    .STABLE_CYCLES  (2),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (8)
  ) dut (
    .core_clk    (core_clk),
    .core_rstn   (core_rstn),
    .checkbits   (checkbits),
    .clear       (clear),
    .event_valid (event_valid),
    .event_code  (event_code),
    .stage       (stage),
    .pass_mask   (pass_mask),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .seq_err     (seq_err),
    .timeout     (timeout),
    .fail_code   (fail_code)
  );

  always #5 core_clk = ~core_clk;

  // Running count of event pulses seen by the bench.
  always @(posedge core_clk) begin
    if (core_rstn && event_valid) ev_cnt <= ev_cnt + 1;
  end

  task automatic apply_reset();
    @(negedge core_clk);
    core_rstn = 1'b0;
    checkbits = 16'h0000;
    clear     = 1'b0;
    repeat (2) @(negedge core_clk);
    core_rstn = 1'b1;
  endtask

  task automatic hold(input logic [15:0] v, input int n);
    checkbits = v;
    repeat (n) @(negedge core_clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({event_valid, event_code, stage, pass_mask, done, pass, fail, seq_err, timeout, fail_code} !== 43'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {event_valid, event_code, stage, pass_mask, done, pass, fail, seq_err, timeout, fail_code});
    end
  endtask

  task automatic test_latency();
    apply_reset();
    checkbits = 16'hA040;
    @(negedge core_clk);
    checks++; if (event_valid !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", event_valid); end
    @(negedge core_clk);
    checks++; if (event_valid !== 1'b1) begin failures++; $display("FAIL lat_pulse got=%b exp=1", event_valid); end
    checks++; if (event_code !== 16'hA040) begin failures++; $display("FAIL lat_code got=%h exp=a040", event_code); end
    checks++; if (stage !== 2'd1) begin failures++; $display("FAIL lat_stage got=%0d exp=1", stage); end
    @(negedge core_clk);
    checks++; if (event_valid !== 1'b0) begin failures++; $display("FAIL lat_single got=%b exp=0", event_valid); end
  endtask

  task automatic test_full_pass();
    int ev0;
    apply_reset();
    ev0 = ev_cnt;
    hold(16'hA040, 10); hold(16'hAB41, 10); hold(16'hA020, 10);
    hold(16'hAB21, 10); hold(16'hA010, 10); hold(16'hAB11, 10);
    checks++; if (ev_cnt - ev0 !== 6) begin failures++; $display("FAIL full_events got=%0d exp=6", ev_cnt - ev0); end
    checks++; if (pass_mask !== 3'b111) begin failures++; $display("FAIL full_mask got=%b exp=111", pass_mask); end
    checks++; if ({pass, done, fail} !== 3'b110) begin failures++; $display("FAIL full_flags got=%b exp=110", {pass, done, fail}); end
    checks++; if (stage !== 2'd3) begin failures++; $display("FAIL full_stage got=%0d exp=3", stage); end
    // Codes after PASS still pulse but change no status.
    hold(16'hAB40, 2);
    checks++; if ({event_valid, event_code} !== {1'b1, 16'hAB40}) begin failures++; $display("FAIL term_event got=%b/%h exp=1/ab40", event_valid, event_code); end
    checks++; if ({pass, fail, fail_code} !== {1'b1, 1'b0, 16'h0000}) begin failures++; $display("FAIL term_status got=%b%b/%h exp=10/0000", pass, fail, fail_code); end
  endtask

  task automatic test_phase_fail();
    apply_reset();
    hold(16'hA040, 10); hold(16'hAB40, 10);
    checks++; if ({fail, seq_err, done, pass} !== 4'b1010) begin failures++; $display("FAIL pf_flags got=%b exp=1010", {fail, seq_err, done, pass}); end
    checks++; if (fail_code !== 16'hAB40) begin failures++; $display("FAIL pf_code got=%h exp=ab40", fail_code); end
    checks++; if (pass_mask !== 3'b000) begin failures++; $display("FAIL pf_mask got=%b exp=000", pass_mask); end
  endtask

  task automatic test_seq_err();
    apply_reset();
    hold(16'hA040, 10); hold(16'hAB41, 10); hold(16'hA010, 10);
    checks++; if ({fail, seq_err, done} !== 3'b111) begin failures++; $display("FAIL seq_flags got=%b exp=111", {fail, seq_err, done}); end
    checks++; if (fail_code !== 16'hA010) begin failures++; $display("FAIL seq_code got=%h exp=a010", fail_code); end
    checks++; if (pass_mask !== 3'b100) begin failures++; $display("FAIL seq_mask got=%b exp=100", pass_mask); end
  endtask

  task automatic test_glitch();
    int ev0;
    apply_reset();
    ev0 = ev_cnt;
    hold(16'hA040, 1); hold(16'h0000, 5);
    checks++; if (ev_cnt - ev0 !== 0) begin failures++; $display("FAIL glitch_events got=%0d exp=0", ev_cnt - ev0); end
    checks++; if (stage !== 2'd0) begin failures++; $display("FAIL glitch_stage got=%0d exp=0", stage); end
    hold(16'h1234, 10);
    checks++; if (ev_cnt - ev0 !== 0) begin failures++; $display("FAIL unknown_events got=%0d exp=0", ev_cnt - ev0); end
    hold(16'hA040, 10);
    checks++; if ({stage, fail} !== {2'd1, 1'b0}) begin failures++; $display("FAIL glitch_idle got=%0d/%b exp=1/0", stage, fail); end
  endtask

  task automatic test_timeout();
    apply_reset();
    checkbits = 16'hA040;
`ifdef MEM_MON_TIMEOUT_EN
    repeat (99) @(negedge core_clk);
    checks++; if ({timeout, fail} !== 2'b00) begin failures++; $display("FAIL to_early got=%b exp=00", {timeout, fail}); end
    @(negedge core_clk);
    checks++; if ({timeout, fail, seq_err, done} !== 4'b1101) begin failures++; $display("FAIL to_flags got=%b exp=1101", {timeout, fail, seq_err, done}); end
    checks++; if (fail_code !== 16'hA040) begin failures++; $display("FAIL to_code got=%h exp=a040", fail_code); end
`else
    repeat (150) @(negedge core_clk);
    checks++; if ({timeout, fail} !== 2'b00) begin failures++; $display("FAIL to_off got=%b exp=00", {timeout, fail}); end
    checks++; if (stage !== 2'd1) begin failures++; $display("FAIL to_off_stage got=%0d exp=1", stage); end
`endif
  endtask

  task automatic test_reset_clear();
    apply_reset();
    hold(16'hA040, 10); hold(16'hAB41, 10); hold(16'hA020, 10);
    checks++; if (stage !== 2'd2) begin failures++; $display("FAIL rc_srun got=%0d exp=2", stage); end
    #3 core_rstn = 1'b0;
    #1;
    checks++; if ({event_valid, event_code, stage, pass_mask, done, pass, fail, seq_err, timeout, fail_code} !== 43'd0) begin
      failures++; $display("FAIL rc_async got=%h exp=0", {event_valid, event_code, stage, pass_mask, done, pass, fail, seq_err, timeout, fail_code});
    end
    checkbits = 16'h0000;
    @(negedge core_clk);
    core_rstn = 1'b1;
    hold(16'hA040, 10); hold(16'hAB41, 10); hold(16'hA020, 10); hold(16'hAB21, 10); hold(16'hA010, 10);
    checks++; if ({stage, pass_mask} !== {2'd3, 3'b110}) begin failures++; $display("FAIL rc_brun got=%0d/%b exp=3/110", stage, pass_mask); end
    clear = 1'b1;
    @(negedge core_clk);
    clear = 1'b0;
    checks++; if ({event_valid, event_code, stage, pass_mask, done, pass, fail, seq_err, timeout, fail_code} !== 43'd0) begin
      failures++; $display("FAIL rc_clear got=%h exp=0", {event_valid, event_code, stage, pass_mask, done, pass, fail, seq_err, timeout, fail_code});
    end
    @(negedge core_clk);
    checks++; if ({event_valid, fail} !== 2'b00) begin failures++; $display("FAIL rc_early got=%b exp=00", {event_valid, fail}); end
    @(negedge core_clk);
    checks++; if ({event_valid, fail, seq_err} !== 3'b111) begin failures++; $display("FAIL rc_reaccept got=%b exp=111", {event_valid, fail, seq_err}); end
    checks++; if (fail_code !== 16'hA010) begin failures++; $display("FAIL rc_code got=%h exp=a010", fail_code); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_pass();
    test_phase_fail();
    test_seq_err();
    test_glitch();
    test_timeout();
    test_reset_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
